free_index_allocator: RTL

- Allocates free entry indices (physical registers, ROB or queue slots) from a WIDTH-bit free bitmap.
- Drives the bitmap into priority_finder (FIRST_PRIORITY=1, WIDTH=WIDTH) and consumes its index/index_valid.
- Presents one pre-reserved index per cycle through a valid/ready handshake.
- Accepts single-index releases and a global flush.

---
 rtl/free_index_allocator.sv | 135 +++++++++++++
 1 files changed

// File: rtl/free_index_allocator.sv
// free_index_allocator: hands out free entry indices from a WIDTH-bit free
// bitmap through a one-deep valid/ready offer slot, and takes single-index
// releases and a global flush.
// Optional feature macro: FREE_INDEX_ALLOCATOR_RELEASE_CHECK_EN adds a sticky
// release_error flag plus a simulation assertion on illegal releases.

`timescale 1ns/1ps

// priority_finder: index of the first set request bit (lowest when
// FIRST_PRIORITY=1, highest otherwise).
module priority_finder #(
  parameter int unsigned WIDTH          = 32,
  parameter bit          FIRST_PRIORITY = 1'b1,
  parameter int unsigned INDEX_W        = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   req,
  output logic [INDEX_W-1:0] index,
  output logic               index_valid
);

  // Scan so that the winning position is the last one written.
  always_comb begin
    index       = '0;
    index_valid = |req;
    if (FIRST_PRIORITY) begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (req[i]) index = INDEX_W'(i);
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (req[i]) index = INDEX_W'(i);
      end
    end
  end

endmodule

module free_index_allocator #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned INDEX_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               alloc_valid,
  output logic [INDEX_W-1:0] alloc_index,
  input  logic               alloc_ready,
  input  logic               release_valid,
  input  logic [INDEX_W-1:0] release_index,
  input  logic               flush,
  output logic [INDEX_W:0]   free_count,
  output logic               release_error
);

  localparam int unsigned COUNT_W = INDEX_W + 1;

  logic [WIDTH-1:0]   free_bitmap;
  logic [INDEX_W-1:0] found_index;
  logic               found_valid;
  logic               slot_open;
  logic               reserve;
  logic               rel_illegal;
  logic               rel_ok;
  logic [WIDTH-1:0]   release_mask;
  logic [WIDTH-1:0]   reserve_mask;

  // Lowest free entry of the current (pre-release) bitmap, used unregistered.
  priority_finder #(
    .WIDTH          (WIDTH),
    .FIRST_PRIORITY (1'b1),
    .INDEX_W        (INDEX_W)
  ) u_finder (
    .req         (free_bitmap),
    .index       (found_index),
    .index_valid (found_valid)
  );

  // Slot reload decision and release legality for this cycle.
  always_comb begin
    slot_open    = !alloc_valid || alloc_ready;
    reserve      = slot_open && found_valid;
    // A release is illegal if the entry is already free or is sitting in the
    // offer slot (its bitmap bit is clear but it was never handed out).
    rel_illegal  = release_valid &&
                   (free_bitmap[release_index] ||
                    (alloc_valid && (release_index == alloc_index)));
    rel_ok       = release_valid && !rel_illegal;
    release_mask = rel_ok  ? (WIDTH'(1) << release_index) : '0;
    reserve_mask = reserve ? (WIDTH'(1) << found_index)   : '0;
  end

  // Bitmap, offer slot and free counter; flush overrides everything else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      free_bitmap <= '1;
      alloc_valid <= 1'b0;
      alloc_index <= '0;
      free_count  <= COUNT_W'(WIDTH);
    end else if (flush) begin
      free_bitmap <= '1;
      alloc_valid <= 1'b0;
      alloc_index <= '0;
      free_count  <= COUNT_W'(WIDTH);
    end else begin
      // Reserved and released positions never coincide: the found entry is
      // free, and releasing a free entry is illegal.
      free_bitmap <= (free_bitmap & ~reserve_mask) | release_mask;
      if (slot_open) begin
        alloc_valid <= found_valid;
        if (found_valid) alloc_index <= found_index;
      end
      free_count  <= free_count + COUNT_W'(rel_ok) - COUNT_W'(reserve);
    end
  end

`ifdef FREE_INDEX_ALLOCATOR_RELEASE_CHECK_EN
  // Sticky illegal-release flag, cleared by reset or flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      release_error <= 1'b0;
    end else if (flush) begin
      release_error <= 1'b0;
    end else if (rel_illegal) begin
      release_error <= 1'b1;
    end
  end

  // Releases dropped by a flush are not reported.
  illegal_release_a: assert property (
    @(posedge clk) disable iff (!rst) !(!flush && rel_illegal)
  );
`else
  assign release_error = 1'b0;
`endif

endmodule
